mdu_iterative: RTL and testbench

- Multi-cycle multiply/divide unit that sits beside the single-cycle ALU in the execute stage.
- Multiply and divide ops are issued here instead of to the ALU; the unit writes a HI/LO result pair.
- The pipeline is the initiator and this block is the responder. The pipeline stalls on busy and captures hi/lo on done.
- Shift-add multiply and restoring divide, one bit per cycle.

---
 rtl/mdu_pkg.sv | 19 +
 rtl/mdu_sign_fix.sv | 39 +++
 rtl/mdu_iterative.sv | 153 +++++++++++++++
 tb/tb_mdu_iterative.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state type and the two's-complement magnitude helper.
package mdu_pkg;

    localparam int MDU_XLEN = 32;

    localparam logic [1:0] MDU_MULT  = 2'd0;
    localparam logic [1:0] MDU_MULTU = 2'd1;
    localparam logic [1:0] MDU_DIV   = 2'd2;
    localparam logic [1:0] MDU_DIVU  = 2'd3;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} mdu_state_t;

    function automatic logic [MDU_XLEN-1:0] twos_mag(input logic [MDU_XLEN-1:0] x,
                                                      input logic neg);
        return neg ? (~x + MDU_XLEN'(1)) : x;
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Sign handling around the unsigned iterative core: operand magnitudes and
// result signs at issue, and the final negation of the raw result in FIX.
module mdu_sign_fix
    import mdu_pkg::*;
#(
    parameter int XLEN = MDU_XLEN
) (
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic [1:0]      i_res_op,
    input  logic [XLEN-1:0] i_acc,
    input  logic [XLEN-1:0] i_mq,
    input  logic            i_neg_lo,
    input  logic            i_neg_hi,
    output logic [XLEN-1:0] o_mag_a,
    output logic [XLEN-1:0] o_mag_b,
    output logic            o_neg_lo,
    output logic            o_neg_hi,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo
);
    logic w_signed, w_sa, w_sb;

    assign w_signed = (i_op == MDU_MULT) || (i_op == MDU_DIV);
    assign w_sa     = w_signed & i_a[XLEN-1];
    assign w_sb     = w_signed & i_b[XLEN-1];
    assign o_mag_a  = twos_mag(i_a, w_sa);
    assign o_mag_b  = twos_mag(i_b, w_sb);
    assign o_neg_lo = w_sa ^ w_sb;
    // Product negates as a whole; a divide remainder follows the dividend.
    assign o_neg_hi = (i_op == MDU_MULT) ? (w_sa ^ w_sb) : w_sa;

    assign o_lo = twos_mag(i_mq, i_neg_lo);
    // Negating a double-width product: the upper half only takes the +1
    // carry when the lower half is zero, otherwise it is a plain invert.
    assign o_hi = (i_res_op == MDU_MULT && i_neg_hi && i_mq != '0) ? ~i_acc
                                                                    : twos_mag(i_acc, i_neg_hi);
endmodule

// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle. Define MDU_EARLY_OUT_EN for data-dependent multiply exit.
module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int XLEN = MDU_XLEN
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] input1,
    input  logic [XLEN-1:0] input2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            div_by_zero
);
    localparam int CW = $clog2(XLEN + 1);

    mdu_state_t      r_state;
    logic [1:0]      r_op;
    logic [CW-1:0]   r_count;
    logic [XLEN-1:0] r_acc, r_mq, r_b;
    logic            r_neg_lo, r_neg_hi, r_dz;

    logic [XLEN-1:0]   w_mag_a, w_mag_b, w_res_hi, w_res_lo;
    logic              w_neg_lo, w_neg_hi, w_early;
    logic [XLEN:0]     w_sum, w_rem_sh;
    logic [XLEN-1:0]   w_diff;
    logic              w_ge;
    logic [2*XLEN-1:0] w_step, w_mul_next;

    mdu_sign_fix #(.XLEN(XLEN)) u_sign_fix (
        .i_op     (op),
        .i_a      (input1),
        .i_b      (input2),
        .i_res_op (r_op),
        .i_acc    (r_acc),
        .i_mq     (r_mq),
        .i_neg_lo (r_neg_lo),
        .i_neg_hi (r_neg_hi),
        .o_mag_a  (w_mag_a),
        .o_mag_b  (w_mag_b),
        .o_neg_lo (w_neg_lo),
        .o_neg_hi (w_neg_hi),
        .o_hi     (w_res_hi),
        .o_lo     (w_res_lo)
    );

    assign w_sum  = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_b} : '0);
    assign w_step = {w_sum[XLEN:1], w_sum[0], r_mq[XLEN-1:1]};

    assign w_rem_sh = {r_acc, r_mq[XLEN-1]};
    assign w_ge     = w_rem_sh >= {1'b0, r_b};
    assign w_diff   = w_rem_sh[XLEN-1:0] - r_b;

`ifdef MDU_EARLY_OUT_EN
    // Multiplier bits [count-1:1] are the ones not yet consumed after this step.
    logic [XLEN-1:0] w_rest_mask;
    assign w_rest_mask = ((XLEN'(1) << r_count) - XLEN'(1)) & ~XLEN'(1);
    assign w_early     = !r_op[1] && ((r_mq & w_rest_mask) == '0);
    assign w_mul_next  = w_early ? (w_step >> (r_count - CW'(1))) : w_step;
`else
    assign w_early    = 1'b0;
    assign w_mul_next = w_step;
`endif

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state     <= IDLE;
            r_op        <= MDU_MULT;
            r_count     <= '0;
            r_acc       <= '0;
            r_mq        <= '0;
            r_b         <= '0;
            r_neg_lo    <= 1'b0;
            r_neg_hi    <= 1'b0;
            r_dz        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // busy is still high during the done cycle, which masks start.
                    busy <= 1'b0;
                    if (start && !busy && !flush) begin
                        busy     <= 1'b1;
                        r_op     <= op;
                        r_neg_lo <= w_neg_lo;
                        r_neg_hi <= w_neg_hi;
                        if (op[1] && input2 == '0) begin
                            r_acc   <= input1;
                            r_mq    <= '1;
                            r_dz    <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_acc   <= '0;
                            r_mq    <= op[1] ? w_mag_a : w_mag_b;
                            r_b     <= op[1] ? w_mag_b : w_mag_a;
                            r_dz    <= 1'b0;
                            r_count <= CW'(XLEN);
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (flush) begin
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        if (r_op[1]) begin
                            r_acc <= w_ge ? w_diff : w_rem_sh[XLEN-1:0];
                            r_mq  <= {r_mq[XLEN-2:0], w_ge};
                        end else begin
                            {r_acc, r_mq} <= w_mul_next;
                        end
                        r_count <= w_early ? '0 : r_count - CW'(1);
                        if (w_early || r_count == CW'(1)) r_state <= FIX;
                    end
                end
                FIX: begin
                    if (flush) begin
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_acc   <= w_res_hi;
                        r_mq    <= w_res_lo;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    if (flush) begin
                        busy <= 1'b0;
                    end else begin
                        done        <= 1'b1;
                        hi          <= r_acc;
                        lo          <= r_mq;
                        div_by_zero <= r_dz;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_iterative.sv
// Scoreboard bench for mdu_iterative: stimulus pushes reference results,
// a negedge monitor pops and compares on every done pulse.
module tb_mdu_iterative;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] input1 = '0, input2 = '0;
    logic        flush = 1'b0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    mdu_iterative #(.XLEN(32)) dut (
        .clk(clk), .rst_b(rst_b), .start(start), .op(op),
        .input1(input1), .input2(input2), .flush(flush),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
        int          t0;
    } exp_t;

    exp_t q[$];
    int n_chk = 0, n_fail = 0;
    logic [31:0] last_hi = '0, last_lo = '0;
    logic        last_dz = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV division truncates toward zero
    // and % takes the dividend's sign, matching the MIPS-style result.
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        longint sa, sb, p;
        logic [63:0] u;
        e.dz = 1'b0; e.lat = 34; e.t0 = 0; e.hi = '0; e.lo = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (o == MDU_MULTU) begin
            u = {32'd0, a} * {32'd0, b};
            e.hi = u[63:32]; e.lo = u[31:0];
        end else if (o == MDU_MULT) begin
            p = sa * sb;
            e.hi = p[63:32]; e.lo = p[31:0];
        end else if (b == 32'd0) begin
            e.hi = a; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1; e.lat = 1;
        end else if (o == MDU_DIVU) begin
            e.lo = a / b; e.hi = a % b;
        end else begin
            p = sa / sb; e.lo = p[31:0];
            p = sa % sb; e.hi = p[31:0];
        end
`ifdef MDU_EARLY_OUT_EN
        if (!o[1]) begin
            logic [31:0] mag;
            int bl;
            mag = (o == MDU_MULT && b[31]) ? -b : b;
            bl = 0;
            for (int i = 0; i < 32; i++) if (mag[i]) bl = i + 1;
            e.lat = ((bl < 1) ? 1 : bl) + 2;
        end
`endif
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_b && done) begin
            chk("busy_in_done_cycle", {63'd0, busy}, 64'd1);
            if (q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("hi_lo", {hi, lo}, {e.hi, e.lo});
                chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dz});
                chk("latency", 64'(cyc - e.t0), 64'(e.lat));
            end
        end
    end

    task automatic wait_not_busy();
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin @(negedge clk); n++; end
        if (busy) chk("timeout_busy", 64'd1, 64'd0);
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit push);
        exp_t e;
        wait_not_busy();
        start = 1'b1; op = o; input1 = a; input2 = b;
        e = model(o, a, b);
        e.t0 = cyc + 1;
        if (push) begin
            q.push_back(e);
            last_hi = e.hi; last_lo = e.lo; last_dz = e.dz;
        end
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {63'd0, busy}, 64'd1);
    endtask

    task automatic wait_quiet();
        int n = 0;
        while ((busy || q.size() != 0) && n < 300) begin @(negedge clk); n++; end
        if (q.size() != 0) begin
            chk("timeout_done", 64'(q.size()), 64'd0);
            q.delete();
        end
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        int n;

        #1;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        chk("reset_dz", {63'd0, div_by_zero}, 64'd0);
        repeat (2) @(negedge clk);
        rst_b = 1'b1;

        issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        issue(MDU_MULT, -32'sd7, 32'd3, 1);
        issue(MDU_MULT, -32'sd2, -32'sd2, 1);
        issue(MDU_DIV, -32'sd7, 32'd2, 1);
        issue(MDU_DIVU, 32'd100, 32'd7, 1);
        issue(MDU_DIV, 32'd5, 32'd0, 1);
        issue(MDU_DIVU, 32'd9, 32'd3, 1);
        issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        issue(MDU_MULT, 32'h8000_0000, 32'h8000_0000, 1);
        wait_quiet();

        // start during the done cycle must be dropped
        issue(MDU_DIVU, 32'd50, 32'd5, 1);
        n = 0;
        while (!done && n < 60) begin @(negedge clk); n++; end
        start = 1'b1; op = MDU_MULTU; input1 = 32'd7; input2 = 32'd7;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_done_ignored", {63'd0, busy}, 64'd0);
        wait_quiet();

        // ignored restart, then flush mid-run: no done, outputs untouched
        issue(MDU_MULTU, 32'd3, 32'd4, 0);
        repeat (8) @(negedge clk);
        start = 1'b1; op = MDU_DIVU; input1 = 32'd77; input2 = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {63'd0, busy}, 64'd0);
        chk("flush_hilo_hold", {hi, lo}, {last_hi, last_lo});
        issue(MDU_MULTU, 32'd3, 32'd4, 1);
        wait_quiet();

        // flush landing on the DONE state of a divide-by-zero
        issue(MDU_DIV, 32'd123, 32'd0, 0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        chk("flush_done_busy", {63'd0, busy}, 64'd0);
        chk("flush_done_hilo", {hi, lo}, {last_hi, last_lo});
        chk("flush_done_dz", {63'd0, div_by_zero}, {63'd0, last_dz});

        // flush in IDLE blocks a same-cycle start
        start = 1'b1; flush = 1'b1; op = MDU_MULTU; input1 = 32'd2; input2 = 32'd2;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_idle_blocks_start", {63'd0, busy}, 64'd0);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 3))
                0: ;
                1: begin ra = $urandom_range(0, 300); rb = $urandom_range(0, 20); end
                2: rb = 32'd0;
                default: begin
                    ra = $urandom_range(0, 1) ? 32'h8000_0000 : 32'hFFFF_FFFF;
                    rb = $urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'h0000_0001;
                end
            endcase
            issue(ro, ra, rb, 1);
        end
        wait_quiet();

        // asynchronous reset in the middle of a divide
        issue(MDU_DIVU, 32'hDEAD_BEEF, 32'd3, 0);
        repeat (14) @(negedge clk);
        rst_b = 1'b0;
        #1;
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_done", {63'd0, done}, 64'd0);
        chk("arst_hilo", {hi, lo}, 64'd0);
        chk("arst_dz", {63'd0, div_by_zero}, 64'd0);
        @(negedge clk);
        rst_b = 1'b1;
        issue(MDU_DIV, -32'sd100, 32'd7, 1);
        wait_quiet();

`ifdef MDU_EARLY_OUT_EN
        issue(MDU_MULTU, 32'h1234, 32'd1, 1);
        issue(MDU_MULT, 32'd5, -32'sd4, 1);
        wait_quiet();
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
